// File: rtl/cpu_pkg.sv
// Shared pipeline types: data-cache controller states and default line geometry.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL} dcache_state_t;

  localparam int DC_LINES  = 32;
  localparam int DC_IDX_W  = $clog2(DC_LINES);
  localparam int DC_TAG_W  = 30 - DC_IDX_W;
  localparam int DC_LINE_W = 2 + DC_TAG_W + 32;
endpackage

// File: rtl/dcache_sram.sv
// Line storage for the direct-mapped data cache: async read, sync write,
// valid/dirty cleared by reset (tag/data left uninitialised).
module dcache_sram
  import cpu_pkg::*;
#(
  parameter  int LINES = DC_LINES,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic             dirty_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [31:0]      data_o,
  input  logic             we_i,
  input  logic             dirty_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [31:0]      data_i
);
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= data_i;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller: hits in the
// access cycle, misses stall the pipeline through a write-back/refill handshake.
module dcache_ctrl
  import cpu_pkg::*;
#(
  parameter int LINES = DC_LINES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        hold_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  dcache_state_t state_q, state_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             l_valid, l_dirty, hit;
  logic [TAG_W-1:0] l_tag;
  logic [31:0]      l_data;
  logic             wr_en, wr_dirty;
  logic [31:0]      wr_data;
  logic             unused_addr;

  assign idx         = cpu_addr_i[IDX_W+1:2];
  assign tag         = cpu_addr_i[31:IDX_W+2];
  assign hit         = cpu_req_i & l_valid & (l_tag == tag);
  assign unused_addr = &{1'b0, cpu_addr_i[1:0]};

  dcache_sram #(.LINES(LINES)) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .idx_i   (idx),
    .valid_o (l_valid),
    .dirty_o (l_dirty),
    .tag_o   (l_tag),
    .data_o  (l_data),
    .we_i    (wr_en),
    .dirty_i (wr_dirty),
    .tag_i   (tag),
    .data_i  (wr_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Reset forces state to IDLE asynchronously; gating the IDLE miss term with
  // rst_i keeps hold_o low while reset is held even if cpu_req_i is high.
  always_comb begin
    state_d    = state_q;
    hold_o     = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    cpu_data_o = '0;
    wr_en      = 1'b0;
    wr_dirty   = 1'b0;
    wr_data    = cpu_data_i;
    case (state_q)
      IDLE: begin
        if (hit) begin
          cpu_data_o = l_data;
          wr_en      = cpu_we_i;
          wr_dirty   = 1'b1;
        end else if (cpu_req_i) begin
          hold_o  = rst_i;
          state_d = (l_valid & l_dirty) ? WB : FILL;
        end
      end
      WB: begin
        hold_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {l_tag, idx, 2'b00};
        mem_data_o = l_data;
        if (mem_ack_i) state_d = FILL;
      end
      FILL: begin
        hold_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {cpu_addr_i[31:2], 2'b00};
        if (mem_ack_i) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
          wr_data  = mem_data_i;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomised and directed checks of dcache_ctrl against an array/queue reference
// model and a latency-programmable word memory.
module tb_dcache_ctrl;
  localparam int LINES = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_data_o, mem_addr_o, mem_data_o, mem_data_i;
  logic        hold_o, mem_req_o, mem_we_o, mem_ack_i;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(LINES)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_wdata),
    .cpu_data_o (cpu_data_o),
    .hold_o     (hold_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- memory device: ack after `lat` wait cycles, stores write-backs ----
  bit          mem_en = 1'b1;
  int          lat = 2, cnt = 0;
  logic        dev_ack = 1'b0, ack_force = 1'b0;
  logic [31:0] dev_data = '0, force_data = '0;
  logic [31:0] dev_mem [bit [29:0]];

  assign mem_ack_i  = dev_ack | ack_force;
  assign mem_data_i = ack_force ? force_data : dev_data;

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a[31:2]) ? dev_mem[a[31:2]] : (a ^ 32'hA5A5_0000);
  endfunction

  always @(negedge clk) begin
    #1;
    dev_ack = 1'b0;
    if (!mem_en) cnt = 0;
    else if (mem_req_o) begin
      if (cnt == lat) begin
        dev_ack = 1'b1;
        cnt = 0;
        if (mem_we_o) dev_mem[mem_addr_o[31:2]] = mem_data_o;
        else dev_data = dev_rd(mem_addr_o);
      end else cnt++;
    end else cnt = 0;
  end

  // ---- transaction monitor ----
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} tx_t;
  tx_t txq[$];

  always @(posedge clk)
    if (rst_n && mem_req_o && mem_ack_i)
      txq.push_back({mem_we_o, mem_addr_o, mem_we_o ? mem_data_o : mem_data_i});

  // ---- reference model ----
  bit          r_v [LINES], r_d [LINES];
  logic [24:0] r_t [LINES];
  logic [31:0] r_dat [LINES];
  logic [31:0] ref_mem [bit [29:0]];

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : ({w, 2'b00} ^ 32'hA5A5_0000);
  endfunction

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input int l, input string nm,
                        output int stalls, output logic [31:0] rd);
    logic [4:0]  idx;
    logic [24:0] tg;
    tx_t         exp[$];
    int          es;
    logic [31:0] ed;
    idx = a[6:2];
    tg  = a[31:7];
    es  = 0;
    if (!(r_v[idx] && r_t[idx] == tg)) begin
      es = 1;
      if (r_v[idx] && r_d[idx]) begin
        exp.push_back({1'b1, r_t[idx], idx, 2'b00, r_dat[idx]});
        ref_mem[{r_t[idx], idx}] = r_dat[idx];
        es += l + 1;
      end
      exp.push_back({1'b0, a[31:2], 2'b00, ref_rd(a[31:2])});
      es += l + 1;
      r_v[idx] = 1'b1; r_d[idx] = 1'b0; r_t[idx] = tg; r_dat[idx] = ref_rd(a[31:2]);
    end
    ed = r_dat[idx];
    if (we) begin r_dat[idx] = d; r_d[idx] = 1'b1; end

    lat = l;
    txq.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    stalls = 0;
    #2;
    while (hold_o === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #2;
    end
    rd = cpu_data_o;
    chk({nm, " stall"}, 32'(stalls), 32'(es));
    chk({nm, " data"}, rd, ed);
    chk({nm, " req idle"}, {31'b0, mem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    chk({nm, " tx count"}, 32'(txq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
      chk({nm, " tx we"},   {31'b0, txq[i].we}, {31'b0, exp[i].we});
      chk({nm, " tx addr"}, txq[i].addr, exp[i].addr);
      chk({nm, " tx data"}, txq[i].data, exp[i].data);
    end
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    // reset state, with a request pending to show hold stays low under reset
    cpu_req = 1'b1; cpu_addr = 32'h40;
    #12;
    chk("rst hold", {31'b0, hold_o}, 32'd0);
    chk("rst req", {31'b0, mem_req_o}, 32'd0);
    chk("rst we", {31'b0, mem_we_o}, 32'd0);
    chk("rst addr", mem_addr_o, 32'd0);
    chk("rst mdata", mem_data_o, 32'd0);
    chk("rst cdata", cpu_data_o, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    access(1'b0, 32'h40, 32'h0, 2, "cold ld", st, rd);
    chk("cold ld stall4", 32'(st), 32'd4);
    chk("cold ld val", rd, 32'hA5A5_0040);
    access(1'b1, 32'h40, 32'h1234_5678, 2, "st hit", st, rd);
    chk("st hit nostall", 32'(st), 32'd0);
    access(1'b0, 32'h40, 32'h0, 2, "ld after st", st, rd);
    chk("ld after st val", rd, 32'h1234_5678);
    access(1'b0, 32'hC0, 32'h0, 2, "conflict", st, rd);
    chk("conflict stall7", 32'(st), 32'd7);
    chk("conflict val", rd, 32'hA5A5_00C0);
    access(1'b1, 32'h100, 32'hCAFE_F00D, 0, "st miss lat0", st, rd);
    chk("st miss stall2", 32'(st), 32'd2);
    access(1'b0, 32'h180, 32'h0, 0, "evict", st, rd);
    chk("evict stall3", 32'(st), 32'd3);

    // spurious ack while idle
    @(negedge clk); #1;
    force_data = 32'hDEAD_BEEF; ack_force = 1'b1;
    #2;
    chk("spur hold", {31'b0, hold_o}, 32'd0);
    @(negedge clk); #1; ack_force = 1'b0;
    access(1'b0, 32'h180, 32'h0, 2, "after spur", st, rd);
    chk("after spur val", rd, 32'hA5A5_0180);

    // reset in the middle of a refill
    lat = 5;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(negedge clk); @(negedge clk);
    #3;
    chk("pre-rst req", {31'b0, mem_req_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst req", {31'b0, mem_req_o}, 32'd0);
    chk("mid rst hold", {31'b0, hold_o}, 32'd0);
    chk("mid rst addr", mem_addr_o, 32'd0);
    mem_en = 1'b0;
    @(negedge clk); cpu_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1; force_data = 32'hBAD0_BAD0; ack_force = 1'b1;
    @(negedge clk); #1; ack_force = 1'b0;
    #1;
    chk("late ack hold", {31'b0, hold_o}, 32'd0);
    chk("late ack req", {31'b0, mem_req_o}, 32'd0);
    for (int i = 0; i < LINES; i++) begin r_v[i] = 1'b0; r_d[i] = 1'b0; end
    mem_en = 1'b1;
    access(1'b0, 32'h40, 32'h0, 2, "post rst", st, rd);
    chk("post rst stall4", 32'(st), 32'd4);

    // random traffic over a few indices and tags to force conflicts
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = {23'($urandom_range(0, 3)), 2'b00, 5'($urandom_range(0, 3)), 2'($urandom)};
      access(1'($urandom), a, $urandom, $urandom_range(0, 3), "rnd", st, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
